// File: rtl/mem_miss_controller.sv
// mem_miss_controller: MEM-stage data-cache miss sequencer (stall, bubble, line refill); optional MISS_COUNTER_EN adds missCount
module mem_miss_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WORDS_PER_LINE = 4,
    localparam int IDX_W = $clog2(WORDS_PER_LINE)
) (
    input  logic                  clockPulse,
    input  logic                  reset,
    input  logic                  memAccess,
    input  logic                  hit,
    input  logic [ADDR_WIDTH-1:0] missAddr,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic                  memAck,
    input  logic [DATA_WIDTH-1:0] memRdata,
    output logic                  refillWe,
    output logic [IDX_W-1:0]      refillWordIdx,
    output logic [DATA_WIDTH-1:0] refillData,
    output logic                  stall,
    output logic                  memWbBubble,
`ifdef MISS_COUNTER_EN
    output logic [31:0]           missCount,
`endif
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(4 * WORDS_PER_LINE - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS_PER_LINE - 1);
    state_t state, nextState;
    logic [IDX_W-1:0] wordCnt;
    logic [ADDR_WIDTH-1:0] lineBase;
    logic miss, inReq;
    // next state and all outputs; the miss term gives zero-latency stall
    always_comb begin
        miss = (state == IDLE) & memAccess & ~hit;
        inReq = state == REQ;
        nextState = (state == IDLE) ? (miss ? REQ : IDLE) :
                    (state == REQ) ? ((memAck && wordCnt == LAST) ? DONE : REQ) : IDLE;
        memReq = inReq;
        memAddr = inReq ? lineBase + ADDR_WIDTH'({wordCnt, 2'b00}) : '0;
        refillWe = inReq & memAck;
        refillWordIdx = wordCnt;
        refillData = memRdata;
        busy = state != IDLE;
        stall = busy | miss;
        memWbBubble = stall;
    end
    // state register
    always_ff @(posedge clockPulse or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end
    // line base capture on miss, word counter advances (and wraps) on each accepted ack
    always_ff @(posedge clockPulse or posedge reset) begin
        if (reset) begin
            wordCnt <= '0;
            lineBase <= '0;
        end else if (miss) begin
            wordCnt <= '0;
            lineBase <= missAddr & ~OFF_MASK;
        end else if (refillWe) begin
            wordCnt <= wordCnt + IDX_W'(1);
        end
    end
`ifdef MISS_COUNTER_EN
    // saturating count of refills started
    always_ff @(posedge clockPulse or posedge reset) begin
        if (reset) missCount <= '0;
        else if (miss && missCount != '1) missCount <= missCount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mem_miss_controller.sv
// tb_mem_miss_controller: table-driven check of mem_miss_controller plus slow-memory and mid-refill reset sequences
module tb_mem_miss_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic memAccess = 1'b0, hit = 1'b0, memAck = 1'b0;
    logic [31:0] missAddr = '0, memRdata = '0;
    logic memReq, refillWe, stall, memWbBubble, busy;
    logic [31:0] memAddr, refillData;
    logic [1:0] refillWordIdx;
`ifdef MISS_COUNTER_EN
    logic [31:0] missCount;
`endif
    int nCmp = 0, nFail = 0;

    typedef struct {
        logic acc, hit;
        logic [31:0] addr;
        logic ack;
        logic [31:0] rdata;
        logic eStall, eReq;
        logic [31:0] eAddr;
        logic eWe;
        logic [1:0] eIdx;
        logic eBusy;
    } vec_t;
    vec_t vt[32];

    mem_miss_controller dut (
        .clockPulse(clk), .reset(rst), .memAccess(memAccess), .hit(hit), .missAddr(missAddr),
        .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memRdata(memRdata),
        .refillWe(refillWe), .refillWordIdx(refillWordIdx), .refillData(refillData),
        .stall(stall), .memWbBubble(memWbBubble),
`ifdef MISS_COUNTER_EN
        .missCount(missCount),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic acc, logic h, logic [31:0] addr, logic ack, logic [31:0] rd,
                                logic eStall, logic eReq, logic [31:0] eAddr, logic eWe,
                                logic [1:0] eIdx, logic eBusy);
        vec_t v;
        v.acc = acc; v.hit = h; v.addr = addr; v.ack = ack; v.rdata = rd;
        v.eStall = eStall; v.eReq = eReq; v.eAddr = eAddr; v.eWe = eWe; v.eIdx = eIdx; v.eBusy = eBusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic acc, input logic h, input logic [31:0] addr, input logic ack, input logic [31:0] rd);
        memAccess = acc; hit = h; missAddr = addr; memAck = ack; memRdata = rd;
    endtask

    initial begin
        int stallCyc, wePulses, addrBad;
        // hit path
        vt[0]  = mk(1, 1, 32'h34,  0, 0,     0, 0, 0,      0, 0, 0);
        vt[1]  = mk(1, 1, 32'h38,  0, 0,     0, 0, 0,      0, 0, 0);
        vt[2]  = mk(1, 1, 32'h3C,  0, 0,     0, 0, 0,      0, 0, 0);
        // read miss, ack every cycle: six stall cycles (3..8)
        vt[3]  = mk(1, 0, 32'h34,  0, 0,     1, 0, 0,      0, 0, 0);
        vt[4]  = mk(0, 1, 32'h0,   1, 'hA0,  1, 1, 32'h30, 1, 0, 1);
        vt[5]  = mk(0, 1, 32'h0,   1, 'hA1,  1, 1, 32'h34, 1, 1, 1);
        vt[6]  = mk(0, 1, 32'h0,   1, 'hA2,  1, 1, 32'h38, 1, 2, 1);
        vt[7]  = mk(0, 1, 32'h0,   1, 'hA3,  1, 1, 32'h3C, 1, 3, 1);
        vt[8]  = mk(0, 1, 32'h0,   0, 0,     1, 0, 0,      0, 0, 1);
        vt[9]  = mk(1, 1, 32'h34,  0, 0,     0, 0, 0,      0, 0, 0);
        // ignored inputs: spurious ack in IDLE, input churn during REQ, spurious ack in DONE
        vt[10] = mk(0, 0, 32'h0,   1, 'h55,  0, 0, 0,      0, 0, 0);
        vt[11] = mk(1, 0, 32'h1F8, 0, 0,     1, 0, 0,      0, 0, 0);
        vt[12] = mk(1, 0, 32'h400, 0, 0,     1, 1, 32'h1F0, 0, 0, 1);
        vt[13] = mk(0, 1, 32'h999, 1, 'hB0,  1, 1, 32'h1F0, 1, 0, 1);
        vt[14] = mk(1, 1, 32'h0,   1, 'hB1,  1, 1, 32'h1F4, 1, 1, 1);
        vt[15] = mk(1, 0, 32'h0,   0, 0,     1, 1, 32'h1F8, 0, 2, 1);
        vt[16] = mk(0, 0, 32'h44,  1, 'hB2,  1, 1, 32'h1F8, 1, 2, 1);
        vt[17] = mk(1, 0, 32'h88,  1, 'hB3,  1, 1, 32'h1FC, 1, 3, 1);
        vt[18] = mk(1, 0, 32'h500, 1, 'hCC,  1, 0, 0,      0, 0, 1);
        // back-to-back misses with no idle gap
        vt[19] = mk(1, 0, 32'h100, 0, 0,     1, 0, 0,      0, 0, 0);
        vt[20] = mk(0, 1, 32'h0,   1, 'hD0,  1, 1, 32'h100, 1, 0, 1);
        vt[21] = mk(0, 1, 32'h0,   1, 'hD1,  1, 1, 32'h104, 1, 1, 1);
        vt[22] = mk(0, 1, 32'h0,   1, 'hD2,  1, 1, 32'h108, 1, 2, 1);
        vt[23] = mk(0, 1, 32'h0,   1, 'hD3,  1, 1, 32'h10C, 1, 3, 1);
        vt[24] = mk(0, 1, 32'h0,   0, 0,     1, 0, 0,      0, 0, 1);
        vt[25] = mk(1, 0, 32'h200, 0, 0,     1, 0, 0,      0, 0, 0);
        vt[26] = mk(0, 1, 32'h0,   1, 'hE0,  1, 1, 32'h200, 1, 0, 1);
        vt[27] = mk(0, 1, 32'h0,   1, 'hE1,  1, 1, 32'h204, 1, 1, 1);
        vt[28] = mk(0, 1, 32'h0,   1, 'hE2,  1, 1, 32'h208, 1, 2, 1);
        vt[29] = mk(0, 1, 32'h0,   1, 'hE3,  1, 1, 32'h20C, 1, 3, 1);
        vt[30] = mk(0, 1, 32'h0,   0, 0,     1, 0, 0,      0, 0, 1);
        vt[31] = mk(1, 1, 32'h200, 0, 0,     0, 0, 0,      0, 0, 0);

        // reset state, and zero-latency stall while held in reset
        repeat (2) @(negedge clk);
        #1 chk("rst_outs", {memReq, memAddr, refillWe, refillWordIdx, busy, stall, memWbBubble}, '0);
        drive(1, 0, 32'h34, 0, 0);
        #1 chk("rst_miss_stall", {stall, memWbBubble, memReq, busy}, 4'b1100);
        drive(0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b0;

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].acc, vt[i].hit, vt[i].addr, vt[i].ack, vt[i].rdata);
            #1 chk($sformatf("vec%0d", i),
                   {stall, memWbBubble, memReq, memAddr, refillWe, refillWordIdx, busy, refillWe ? refillData : 32'h0},
                   {vt[i].eStall, vt[i].eStall, vt[i].eReq, vt[i].eAddr, vt[i].eWe, vt[i].eIdx, vt[i].eBusy,
                    vt[i].eWe ? vt[i].rdata : 32'h0});
        end
`ifdef MISS_COUNTER_EN
        chk("missCount_table", missCount, 32'd4);
`endif

        // slow memory: ack every third cycle
        stallCyc = 0; wePulses = 0; addrBad = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) drive(1, 0, 32'h34, 0, 0);
            else drive(0, 1, 32'h0, (c % 3) == 0, 32'hF0 + c);
            #1;
            if (stall) stallCyc++;
            if (memReq && memAddr !== 32'h30 + 4 * wePulses) addrBad++;
            if (refillWe) begin
                if (refillData !== 32'hF0 + c) addrBad++;
                wePulses++;
            end
        end
        chk("slow_stall_cycles", stallCyc, 14);
        chk("slow_we_pulses", wePulses, 4);
        chk("slow_addr_data_errors", addrBad, 0);

        // reset after the second ack of a refill
        @(negedge clk) drive(1, 0, 32'h80, 0, 0);
        @(negedge clk) drive(0, 1, 0, 1, 32'h1);
        @(negedge clk) drive(0, 1, 0, 1, 32'h2);
        @(negedge clk) drive(0, 1, 0, 1, 32'h3);
        #1 chk("pre_rst_we", {refillWe, refillWordIdx, memAddr}, {1'b1, 2'd2, 32'h88});
        rst = 1'b1;
        #1 chk("async_rst_drop", {memReq, busy, refillWe, stall}, 4'b0000);
        @(negedge clk) begin rst = 1'b0; drive(0, 0, 0, 0, 0); end
        @(negedge clk) drive(1, 0, 32'h244, 0, 0);
        #1 chk("restart_miss", {stall, busy}, 2'b10);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) drive(0, 1, 0, 1, 32'h70 + k);
            #1 chk($sformatf("restart_word%0d", k), {memReq, memAddr, refillWe, refillWordIdx, refillData},
                   {1'b1, 32'h240 + 4 * k, 1'b1, 2'(k), 32'h70 + k});
        end
        @(negedge clk) drive(0, 1, 0, 0, 0);
        #1 chk("restart_done", {stall, busy, memReq}, 3'b110);
        @(negedge clk) drive(1, 1, 32'h244, 0, 0);
        #1 chk("restart_release", {stall, busy, memReq}, 3'b000);
`ifdef MISS_COUNTER_EN
        chk("missCount_after_rst", missCount, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
        $finish;
    end
endmodule
